// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores to a variable-latency data memory,
// stalls upstream while an access is outstanding, registers MEM/WB outputs.
module mem_access_stage #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     pc_mem,
    input  logic                  registerWriteEnable_i,
    input  logic                  dataWriteEnable_i,
    input  logic                  regSelect_i,
    input  logic [DATA_W-1:0]     dataB_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0]     aluOut_i,
    output logic                  stall_o,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [ADDR_W-1:0]     pc_wb,
    output logic                  registerWriteEnable_wb,
    output logic [REG_ADDR_W-1:0] rd_wb,
    output logic [DATA_W-1:0]     wbData_o,
    output logic                  mem_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_W-1:0]     cap_addr;
    logic [DATA_W-1:0]     cap_wdata;
    logic [REG_ADDR_W-1:0] cap_rd;
    logic [ADDR_W-1:0]     cap_pc;
    logic                  cap_rwe;
    logic                  cap_store;

    logic is_store;
    logic is_load;
    logic is_mem;
    logic timeout;
    logic store_done;
    logic load_done;

    assign is_store   = dataWriteEnable_i;
    assign is_load    = regSelect_i & ~dataWriteEnable_i;
    assign is_mem     = is_store | is_load;
    // Fires in the TIMEOUT-th cycle spent in REQ+RESP; completion wins.
    assign timeout    = (state != IDLE) && (cnt == CNT_W'(TIMEOUT - 1));
    assign store_done = (state == REQ) && cap_store && mem_ready;
    assign load_done  = (state == RESP) && mem_rvalid;

    assign mem_req   = (state == REQ);
    assign mem_we    = cap_store;
    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;

    always_comb begin
        stall_o = 1'b0;
        unique case (state)
            IDLE:    stall_o = is_mem;
            REQ:     stall_o = !(store_done || timeout);
            RESP:    stall_o = !(load_done || timeout);
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                  <= IDLE;
            cnt                    <= '0;
            cap_addr               <= '0;
            cap_wdata              <= '0;
            cap_rd                 <= '0;
            cap_pc                 <= '0;
            cap_rwe                <= 1'b0;
            cap_store              <= 1'b0;
            pc_wb                  <= '0;
            registerWriteEnable_wb <= 1'b0;
            rd_wb                  <= '0;
            wbData_o               <= '0;
            mem_err_o              <= 1'b0;
        end else begin
            if (state != IDLE && cnt != CNT_W'(TIMEOUT))
                cnt <= cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    if (is_mem) begin
                        cap_addr               <= aluOut_i;
                        cap_wdata              <= dataB_i;
                        cap_rd                 <= rd_i;
                        cap_pc                 <= pc_mem;
                        cap_rwe                <= registerWriteEnable_i;
                        cap_store              <= is_store;
                        cnt                    <= '0;
                        registerWriteEnable_wb <= 1'b0;
                        rd_wb                  <= '0;
                        state                  <= REQ;
                    end else begin
                        pc_wb                  <= pc_mem;
                        registerWriteEnable_wb <= registerWriteEnable_i;
                        rd_wb                  <= rd_i;
                        wbData_o               <= aluOut_i;
                    end
                end
                REQ: begin
                    registerWriteEnable_wb <= 1'b0;
                    rd_wb                  <= '0;
                    if (store_done) begin
                        pc_wb    <= cap_pc;
                        wbData_o <= cap_addr;
                        state    <= IDLE;
                    end else if (timeout) begin
                        pc_wb     <= cap_pc;
                        wbData_o  <= '0;
                        mem_err_o <= 1'b1;
                        state     <= IDLE;
                    end else if (mem_ready) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (load_done) begin
                        pc_wb                  <= cap_pc;
                        registerWriteEnable_wb <= cap_rwe;
                        rd_wb                  <= cap_rd;
                        wbData_o               <= mem_rdata;
                        state                  <= IDLE;
                    end else if (timeout) begin
                        registerWriteEnable_wb <= 1'b0;
                        rd_wb                  <= '0;
                        pc_wb                  <= cap_pc;
                        wbData_o               <= '0;
                        mem_err_o              <= 1'b1;
                        state                  <= IDLE;
                    end else begin
                        registerWriteEnable_wb <= 1'b0;
                        rd_wb                  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
